// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. It sends a start bit, 8 data bits LSB first,
// an optional parity bit and one stop bit. Each bit lasts Prescale CLK cycles.
// A Prescale of 0 is treated as 1.
// Optional feature macro: UART_TX_HOLD_EN adds a one-entry holding register,
// so that frames can be sent back-to-back with no idle cycle between them.
module uart_tx_frame #(
    parameter int DATA_WIDTH      = 8,
    parameter int PRESCALAR_WIDTH = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_WIDTH-1:0]      P_DATA,
    input  logic                       DATA_VALID,
    input  logic                       PAR_EN,
    input  logic                       PAR_TYP,
    input  logic [PRESCALAR_WIDTH-1:0] Prescale,
    output logic                       TX_OUT,
    output logic                       Busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                       state, state_nxt;
    logic [PRESCALAR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [2:0]                   idx, idx_nxt;
    logic [DATA_WIDTH-1:0]        data_q;
    logic                         par_en_q, par_typ_q;
    logic [PRESCALAR_WIDTH-1:0]   last_q;     // final cycle index of each bit
    logic                         tx_nxt;
    logic                         accept, bit_end, load_in;

    // Convert the prescale value into the index of the last cycle of a bit.
    // A prescale of 0 behaves the same as a prescale of 1.
    function automatic logic [PRESCALAR_WIDTH-1:0] last_cycle(input logic [PRESCALAR_WIDTH-1:0] p);
        return (p == '0) ? '0 : p - 1'b1;
    endfunction

`ifdef UART_TX_HOLD_EN
    logic                         hold_full, hold_cap, load_hold;
    logic [DATA_WIDTH-1:0]        hold_data;
    logic                         hold_pen, hold_ptyp;
    logic [PRESCALAR_WIDTH-1:0]   hold_last;

    // Busy only reports that the holding slot is occupied.
    assign Busy = hold_full;
`else
    // Busy covers the whole frame, from the start bit through the stop bit.
    assign Busy = (state != IDLE);
`endif

    assign accept  = DATA_VALID && !Busy;
    assign bit_end = (cnt == last_q);

    // Next-state logic, bit/cycle counters and the next serial line value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        load_in   = 1'b0;
`ifdef UART_TX_HOLD_EN
        load_hold = 1'b0;
        hold_cap  = accept && (state != IDLE) && !((state == STOP) && bit_end);
`endif
        if (state == IDLE) begin
            cnt_nxt = '0;
            if (accept) begin
                state_nxt = START;
                load_in   = 1'b1;
            end
        end else if (bit_end) begin
            cnt_nxt = '0;
            unique case (state)
                START: begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                end
                DATA: begin
                    if (idx == 3'd7) state_nxt = par_en_q ? PARITY : STOP;
                    else             idx_nxt   = idx + 3'd1;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
`ifdef UART_TX_HOLD_EN
                    // Chain straight into the next start bit when a word is waiting.
                    if (hold_full) begin
                        state_nxt = START;
                        load_hold = 1'b1;
                    end else if (accept) begin
                        state_nxt = START;
                        load_in   = 1'b1;
                    end
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end

        unique case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[idx_nxt];
            PARITY:  tx_nxt = (^data_q) ^ par_typ_q;
            default: tx_nxt = 1'b1;
        endcase
    end

    // Control registers: FSM state, counters and the registered serial line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            TX_OUT <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            TX_OUT <= tx_nxt;
        end
    end

    // Frame parameters, latched when a frame starts so that later changes to the inputs do not affect it.
    always_ff @(posedge CLK) begin
        if (load_in) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            last_q    <= last_cycle(Prescale);
        end
`ifdef UART_TX_HOLD_EN
        else if (load_hold) begin
            data_q    <= hold_data;
            par_en_q  <= hold_pen;
            par_typ_q <= hold_ptyp;
            last_q    <= hold_last;
        end
`endif
    end

`ifdef UART_TX_HOLD_EN
    // Holding-slot occupancy flag: set on capture, cleared when the word moves to the transmitter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)           hold_full <= 1'b0;
        else if (hold_cap)  hold_full <= 1'b1;
        else if (load_hold) hold_full <= 1'b0;
    end

    // Holding-slot contents, captured while a frame is in flight.
    always_ff @(posedge CLK) begin
        if (hold_cap) begin
            hold_data <= P_DATA;
            hold_pen  <= PAR_EN;
            hold_ptyp <= PAR_TYP;
            hold_last <= last_cycle(Prescale);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame. It checks each frame
// bit by bit, decodes the received byte and checks Busy.
// Test 3 runs only when UART_TX_HOLD_EN is not defined.
// Test 6 runs only when UART_TX_HOLD_EN is defined.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd0;
    logic       TX_OUT;
    logic       Busy;

    int pass_cnt = 0;
    int total    = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALAR_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word at a falling edge, let the next rising edge take it, then drop the strobe.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] pre);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = pre; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    // Entered at the falling edge of the first start-bit cycle; walks the whole frame.
    task automatic frame(input string tag, input logic [7:0] d, input logic pen, input logic exp_par,
                         input int pre, input int inj, input logic [7:0] inj_d, input bit end_idle);
        int         p;
        int         nbits;
        int         busy_bad;
        int         bad;
        int         cyc;
        logic       eb;
        logic       exp_bits [0:10];
        logic [7:0] rx;
        p        = (pre == 0) ? 1 : pre;
        nbits    = pen ? 11 : 10;
        busy_bad = 0;
        rx       = 8'h00;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
        exp_bits[9]  = pen ? exp_par : 1'b1;
        exp_bits[10] = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < p; c++) begin
                cyc = b * p + c;
                if (TX_OUT !== exp_bits[b]) bad++;
                if (c == p / 2 && b >= 1 && b <= 8) rx[b - 1] = TX_OUT;
`ifdef UART_TX_HOLD_EN
                eb = (inj >= 0 && cyc > inj);
`else
                eb = 1'b1;
`endif
                if (Busy !== eb) busy_bad++;
                if (inj >= 0 && cyc == inj) begin
                    P_DATA = inj_d; DATA_VALID = 1'b1;
                end else if (inj >= 0 && cyc == inj + 1) begin
                    DATA_VALID = 1'b0;
                end
                @(negedge CLK);
            end
            chk($sformatf("%s bit%0d bad_cycles", tag, b), bad, 0);
        end
        chk($sformatf("%s rx_byte", tag), {24'd0, rx}, {24'd0, d});
        chk($sformatf("%s busy_bad_cycles", tag), busy_bad, 0);
        if (end_idle) begin
            chk($sformatf("%s idle_tx", tag), {31'd0, TX_OUT}, 32'd1);
            chk($sformatf("%s idle_busy", tag), {31'd0, Busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset tx", {31'd0, TX_OUT}, 32'd1);
        chk("reset busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post-reset idle tx", {31'd0, TX_OUT}, 32'd1);

        // Test 1: 0xCE, even parity (5 ones -> parity 1), Prescale 8, 88 busy cycles.
        send(8'hCE, 1'b1, 1'b0, 6'd8);
        frame("t1", 8'hCE, 1'b1, 1'b1, 8, -1, 8'h00, 1'b1);

        // Test 2: 0xD1, odd parity (4 ones -> parity 1), Prescale 16, 176 cycles.
        send(8'hD1, 1'b1, 1'b1, 6'd16);
        frame("t2", 8'hD1, 1'b1, 1'b1, 16, -1, 8'h00, 1'b1);

`ifndef UART_TX_HOLD_EN
        // Test 3: 0x55 without parity, Prescale 4. A 0xAA request at cycle 10 must be ignored.
        send(8'h55, 1'b0, 1'b0, 6'd4);
        frame("t3", 8'h55, 1'b0, 1'b0, 4, 10, 8'hAA, 1'b1);
        repeat (3) @(negedge CLK);
        chk("t3 no queued frame tx", {31'd0, TX_OUT}, 32'd1);
        chk("t3 no queued frame busy", {31'd0, Busy}, 32'd0);
`endif

        // Test 4: asynchronous reset at cycle 30 of a 0xCE frame, then send 0x12.
        send(8'hCE, 1'b1, 1'b0, 6'd8);
        repeat (30) @(negedge CLK);
`ifndef UART_TX_HOLD_EN
        chk("t4 busy before reset", {31'd0, Busy}, 32'd1);
`endif
        #1 RST = 1'b0;
        #1;
        chk("t4 async reset tx", {31'd0, TX_OUT}, 32'd1);
        chk("t4 async reset busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("t4 dropped frame tx", {31'd0, TX_OUT}, 32'd1);
        send(8'h12, 1'b0, 1'b0, 6'd8);
        frame("t4", 8'h12, 1'b0, 1'b0, 8, -1, 8'h00, 1'b1);

        // Test 5: Prescale 0 behaves as 1, giving a 10-cycle frame for 0x0F.
        send(8'h0F, 1'b0, 1'b0, 6'd0);
        frame("t5", 8'h0F, 1'b0, 1'b0, 0, -1, 8'h00, 1'b1);

`ifdef UART_TX_HOLD_EN
        // Test 6: 0xD1 is held during the 0xCE frame and starts with no idle cycle.
        // Even parity: 0xCE -> 1, 0xD1 -> 0.
        send(8'hCE, 1'b1, 1'b0, 6'd8);
        frame("t6a", 8'hCE, 1'b1, 1'b1, 8, 20, 8'hD1, 1'b0);
        frame("t6b", 8'hD1, 1'b1, 1'b0, 8, -1, 8'h00, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial UART transmitter, the transmit-side counterpart of the UART RX path.
- Accepts an 8-bit parallel word with a valid strobe and serialises it on TX_OUT: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Bit period is Prescale cycles of the single system clock CLK, so the RX and TX sides run on the same clock with the same prescale setting.
- TX_OUT drives the RX_IN of the receiver in loopback benches.

Parameters:
DATA_WIDTH, 8, parallel data width; only 8 is supported.
PRESCALAR_WIDTH, 6, width of Prescale and of the internal cycle counter.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  word to transmit.
DATA_VALID  input  1  request strobe; P_DATA is accepted when DATA_VALID=1 and Busy=0 at a CLK edge.
PAR_EN  input  1  1 = insert a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  PRESCALAR_WIDTH  CLK cycles per bit; 0 is treated as 1.
TX_OUT  output  1  serial line, idle high.
Busy  output  1  transmitter cannot accept a new word.

Behaviour:
- Reset (RST=0, asynchronous, any state): state=IDLE, TX_OUT=1, Busy=0, all counters 0, holding register empty. A frame in progress is dropped with no partial stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: at edge T with DATA_VALID=1 and Busy=0, the block latches P_DATA, PAR_EN, PAR_TYP and Prescale. It enters START with Busy=1 and TX_OUT=0 from T+1. Later input changes have no effect on the current frame.
- Bit timing: each bit is held for exactly Prescale cycles, counted by a cycle counter. The counter reloads at every bit boundary.
- DATA: 8 bits, bit0 first, tracked by a 3-bit index.
  - After bit7: go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: even parity bit = XOR of the 8 data bits; odd parity bit = its inverse.
- STOP: TX_OUT=1 for Prescale cycles. At the last cycle the FSM returns to IDLE and Busy=0 from the next edge.
- Frame length: 10*Prescale cycles without parity, 11*Prescale with parity.
- Busy stays 1 from T+1 through the last stop-bit cycle.
- Back-to-back (no optional feature): Busy=0 for at least one cycle, so there is at least one idle-high cycle between stop and the next start bit.
- DATA_VALID while Busy=1 (no optional feature): ignored, with no state change and no queuing.
- TX_OUT is driven from a register (glitch-free) and never undefined after reset.

Optional Feature:
Macro UART_TX_HOLD_EN.
- Defined: adds a one-entry holding register (data plus PAR_EN, PAR_TYP, Prescale).
  - While a frame is in flight and the holding register is empty, Busy=0 and a DATA_VALID is captured into it.
  - Busy=1 only while the holding register is full.
  - At the last stop-bit cycle with the holding register full, the next edge goes directly to START with zero idle cycles: start bit immediately follows the stop bit. This is the consecutive-frame case the RX must handle.
  - Holding register empties on transfer.
- Undefined: no holding register; behaviour exactly as above.

Test Plan:
1. P_DATA=0xCE, PAR_EN=1, PAR_TYP=0, Prescale=8 -> TX_OUT bits 0, 0,1,1,1,0,0,1,1, parity 1, stop 1, each 8 cycles; Busy high for 88 cycles.
2. P_DATA=0xD1, PAR_EN=1, PAR_TYP=1, Prescale=16 -> data 1,0,0,0,1,0,1,1, parity 1, stop 1; total 176 cycles; loopback RX reports P_DATA=0xD1 with data_valid.
3. P_DATA=0x55, PAR_EN=0, Prescale=4 -> 40-cycle frame 0,1,0,1,0,1,0,1,0,1. A DATA_VALID with 0xAA at cycle 10 is ignored; only 0x55 appears on the line.
4. RST pulsed low at cycle 30 of a 0xCE frame (Prescale=8) -> TX_OUT=1 and Busy=0 immediately, with no clock needed. A new 0x12 accepted afterwards is sent correctly.
5. Prescale=0 with P_DATA=0x0F, PAR_EN=0 -> behaves as Prescale=1: 10-cycle frame 0,1,1,1,1,0,0,0,0,1.
6. With UART_TX_HOLD_EN: send 0xCE then 0xD1 (second accepted during the first frame), Prescale=8, PAR_EN=1 even -> the 0xD1 start bit begins the cycle after the 0xCE stop bit's last cycle; 176 contiguous cycles; RX asserts data_valid twice.
